sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO; the same-clock counterpart to the team's dual-clock FIFO, for datapaths where producer and consumer share one clock.
Adds several features over the dual-clock FIFO:
- selectable standard / first-word-fall-through (FWFT) read mode
- exact occupancy count
- programmable almost-full and almost-empty thresholds
- synchronous flush
- sticky overflow / underflow error flags

Used as the elastic buffer between the packet parser and the checker stages.

Parameters:
DATA_SIZE, 9, data word width in bits
ADDR_SIZE, 9, address width; DEPTH = 1<<ADDR_SIZE words; legal range 2..12
FWFT, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-low reset
flush  in  1  synchronous clear of FIFO contents and error flags
winc  in  1  write request
wData  in  DATA_SIZE  write data
rinc  in  1  read request (FWFT: pop/acknowledge head)
rData  out  DATA_SIZE  read data
rValid  out  1  rData holds a newly read word (standard) / head word valid (FWFT)
wFull  out  1  count == DEPTH
rEmpty  out  1  count == 0
wHalf_full  out  1  count >= DEPTH/2
af_thresh  in  ADDR_SIZE+1  almost-full threshold
ae_thresh  in  ADDR_SIZE+1  almost-empty threshold
wAlmost_full  out  1  count >= af_thresh
rAlmost_empty  out  1  count <= ae_thresh
count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while wFull
underflow  out  1  sticky: read attempted while rEmpty

Behaviour:
Reset and flush
- Clock is clk. Reset rst is synchronous, active-low: sampled only on posedge clk, no asynchronous path.
- Reset values: rptr = wptr = 0, count = 0, rData = 0, rValid = 0, overflow = 0, underflow = 0.
- Resulting flags at reset: rEmpty = 1, wFull = 0, wHalf_full = 0. wAlmost_full and rAlmost_empty follow their thresholds combinationally.
- flush = 1 has the same effect as reset except that memory contents are untouched. flush overrides winc/rinc in the same cycle. rst has priority over flush.
- Reset or flush asserted mid-stream discards all queued words; the next write starts at address 0.

Pointers and storage
- Binary pointers wptr and rptr, each ADDR_SIZE+1 bits; the MSB is the wrap bit. Addresses use the low ADDR_SIZE bits.
- Count is held in a register, not derived from the pointers. It is updated by +1 (write only), -1 (read only), or unchanged (both or neither).

Accept rules (evaluated on the registered state in the current cycle)
- Write accepted when winc && !wFull.
- Read accepted when rinc && !rEmpty.
- Write with winc && wFull: data dropped, pointers unchanged, overflow set next cycle.
- Read with rinc && rEmpty: pointers unchanged, underflow set next cycle.
- overflow and underflow stay set until rst or flush.
- When full with winc && rinc: only the read is accepted, count becomes DEPTH-1 and overflow is set.
- When empty with winc && rinc: only the write is accepted, count becomes 1 and underflow is set (standard and FWFT alike).
- Otherwise simultaneous accepted read and write leave count unchanged.

Flags
- All flags are combinational decodes of the count register, so they change in the cycle after the accepted operation.
- Threshold compares are unsigned.
- af_thresh = 0 forces wAlmost_full = 1.
- ae_thresh >= DEPTH forces rAlmost_empty = 1.
- Thresholds may change at any time; flags follow on the same cycle.

Read path, standard mode (FWFT = 0)
- An accepted read at edge N places mem[raddr] on rData after edge N, with rValid = 1 for exactly that one cycle.
- rData holds its value when no read is accepted.

Read path, FWFT mode (FWFT = 1)
- rValid = !rEmpty. rData always presents the head word mem[rptr], with zero latency from the pointer.
- An accepted rinc advances rptr, and the next word appears the cycle after.
- A word written into an empty FIFO appears on rData one cycle after the write edge, i.e. when count becomes 1.
- rData while empty is don't-care, but it must not be X after reset.

Wrap-around
- Pointers wrap modulo 2*DEPTH.
- Correct operation is required across at least 3 full wraps.

Decomposition:
- Package sync_fifo_pkg holds:
  - function cnt_w(addr) returning ADDR_SIZE+1
  - localparam-style constants for the read modes: FIFO_STD = 0, FIFO_FWFT = 1
  - typedef enum {OP_IDLE, OP_WR, OP_RD, OP_RW} fifo_op_e, used to decode the accepted operation for the count update
- One sub-module, sync_fifo_ram: simple dual-port array with DATA_SIZE × DEPTH storage.
  - Synchronous write.
  - Read port is combinational address-to-data; the top module registers the output in standard mode.
- Top module holds pointers, count, flags, error bits and the read-mode mux.

Test Plan (DATA_SIZE = 9, ADDR_SIZE = 4, DEPTH = 16):
1. Reset then idle: rEmpty = 1, count = 0, rValid = 0, wFull = 0, overflow = underflow = 0. Pulse rinc once -> underflow = 1 on the next cycle and stays 1.
2. FWFT = 0: write 0x001..0x010 (16 words) -> wFull = 1, count = 16, wHalf_full = 1 from count = 8. Then 16 reads -> rData = 0x001..0x010, each one cycle after its rinc, rValid pulsed each time, rEmpty = 1 at the end.
3. Full with winc && rinc on the same cycle -> count = 15, overflow = 1, the data written that cycle is not stored. Empty with winc && rinc -> count = 1, underflow = 1.
4. af_thresh = 12, ae_thresh = 3: fill to 12 -> wAlmost_full rises exactly on the cycle count = 12; drain to 3 -> rAlmost_empty rises on count = 3. Set af_thresh = 0 -> wAlmost_full = 1 immediately.
5. FWFT = 1: write 0x1AA into an empty FIFO -> rValid = 1 and rData = 0x1AA one cycle later with no rinc. Write 0x055, then rinc -> rData = 0x055 next cycle.
6. Continuous random winc/rinc for 100 words (more than 6 wraps), assert flush mid-run, then assert rst mid-burst -> a scoreboard matches in-order data between events; count = 0, rEmpty = 1 and errors cleared after each flush and after rst.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared definitions for the single-clock programmable FIFO:
//   - cnt_w()      : width of pointers/occupancy count for a given address width
//   - FIFO_STD/FWFT: read-mode selector values for the FWFT parameter
//   - fifo_op_e    : decoded accepted operation driving the pointer/count update
package sync_fifo_pkg;

    localparam int FIFO_STD  = 32'd0;
    localparam int FIFO_FWFT = 32'd1;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2,
        OP_RW   = 2'd3
    } fifo_op_e;

    // One extra bit so the count can hold DEPTH and pointers carry a wrap bit.
    function automatic int cnt_w(input int addr);
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
// Simple dual-port storage, DATA_SIZE x (1<<ADDR_SIZE) words.
//   clk     : write clock
//   we_i    : write enable (synchronous write)
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (combinational read)
//   rdata_o : read data, mem[raddr_i]
module sync_fifo_ram #(
    parameter int DATA_SIZE = 9,
    parameter int ADDR_SIZE = 9
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    localparam int DEPTH = 32'd1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
// Single-clock FIFO with standard/FWFT read mode, exact occupancy count,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
//   clk, rst (sync, active-low), flush (sync clear, keeps memory)
//   winc/wData            : write request and data
//   rinc/rData/rValid     : read request (FWFT: pop head), data, valid
//   wFull/rEmpty/wHalf_full, wAlmost_full/rAlmost_empty : count decodes
//   af_thresh/ae_thresh   : almost-full / almost-empty thresholds
//   count                 : occupancy 0..DEPTH
//   overflow/underflow    : sticky error flags
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_SIZE = 9,
    parameter int ADDR_SIZE = 9,
    parameter int FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 winc,
    input  logic [DATA_SIZE-1:0] wData,
    input  logic                 rinc,
    output logic [DATA_SIZE-1:0] rData,
    output logic                 rValid,
    output logic                 wFull,
    output logic                 rEmpty,
    output logic                 wHalf_full,
    input  logic [ADDR_SIZE:0]   af_thresh,
    input  logic [ADDR_SIZE:0]   ae_thresh,
    output logic                 wAlmost_full,
    output logic                 rAlmost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int CW = cnt_w(ADDR_SIZE);
    localparam logic [CW-1:0] DEPTH_C = CW'(32'd1 << ADDR_SIZE);
    localparam logic [CW-1:0] HALF_C  = CW'(32'd1 << (ADDR_SIZE - 1));
    localparam logic [CW-1:0] ONE_C   = CW'(32'd1);

    logic [CW-1:0]        wptr_q, wptr_d;
    logic [CW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic                 full_s, empty_s, wr_acc_s, rd_acc_s;
    logic [DATA_SIZE-1:0] ram_rdata_s;
    fifo_op_e             op_s;

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == {CW{1'b0}});

    sync_fifo_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc_s),
        .waddr_i (wptr_q[ADDR_SIZE-1:0]),
        .wdata_i (wData),
        .raddr_i (rptr_q[ADDR_SIZE-1:0]),
        .rdata_o (ram_rdata_s)
    );

    // Accept decode and next-state for pointers, count, read register and errors.
    always_comb begin
        wr_acc_s = winc && !full_s;
        rd_acc_s = rinc && !empty_s;
        op_s     = fifo_op_e'({rd_acc_s, wr_acc_s});
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        case (op_s)
            OP_WR: begin
                wptr_d  = wptr_q + ONE_C;
                count_d = count_q + ONE_C;
            end
            OP_RD: begin
                rptr_d  = rptr_q + ONE_C;
                count_d = count_q - ONE_C;
            end
            OP_RW: begin
                wptr_d = wptr_q + ONE_C;
                rptr_d = rptr_q + ONE_C;
            end
            default: begin
                count_d = count_q;
            end
        endcase
        // Rejected requests only raise the sticky flags; state is untouched.
        ovf_d    = ovf_q | (winc & full_s);
        udf_d    = udf_q | (rinc & empty_s);
        rvalid_d = rd_acc_s;
        if (rd_acc_s) begin
            rdata_d = ram_rdata_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State register: reset beats flush; flush clears everything but memory.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wptr_q   <= {CW{1'b0}};
            rptr_q   <= {CW{1'b0}};
            count_q  <= {CW{1'b0}};
            rdata_q  <= {DATA_SIZE{1'b0}};
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // FWFT shows the head word directly; masked to zero while empty so the
    // unreset memory never leaks X onto rData.
    assign rData  = (FWFT == FIFO_FWFT) ? (empty_s ? {DATA_SIZE{1'b0}} : ram_rdata_s) : rdata_q;
    assign rValid = (FWFT == FIFO_FWFT) ? !empty_s : rvalid_q;

    assign wFull         = full_s;
    assign rEmpty        = empty_s;
    assign wHalf_full    = (count_q >= HALF_C);
    assign wAlmost_full  = (count_q >= af_thresh);
    assign rAlmost_empty = (count_q <= ae_thresh);
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

    localparam int DW = 9;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, flush, winc, rinc;
    logic [DW-1:0] wData;
    logic [AW:0]   af_thresh, ae_thresh;

    logic [DW-1:0] s_rData, f_rData;
    logic          s_rValid, f_rValid, s_wFull, f_wFull, s_rEmpty, f_rEmpty;
    logic          s_half, f_half, s_af, f_af, s_ae, f_ae;
    logic [AW:0]   s_count, f_count;
    logic          s_ovf, f_ovf, s_udf, f_udf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wData(wData), .rinc(rinc),
        .rData(s_rData), .rValid(s_rValid), .wFull(s_wFull), .rEmpty(s_rEmpty),
        .wHalf_full(s_half), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .wAlmost_full(s_af), .rAlmost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_prog #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wData(wData), .rinc(rinc),
        .rData(f_rData), .rValid(f_rValid), .wFull(f_wFull), .rEmpty(f_rEmpty),
        .wHalf_full(f_half), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .wAlmost_full(f_af), .rAlmost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        winc = 1'b0; rinc = 1'b0; flush = 1'b0; wData = '0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_count"}, 32'(s_count), 32'd0);
        check({tag, "_empty"}, 32'(s_rEmpty), 32'd1);
        check({tag, "_ovf"}, 32'(s_ovf), 32'd0);
        check({tag, "_udf"}, 32'(s_udf), 32'd0);
        check({tag, "_fcount"}, 32'(f_count), 32'd0);
        check({tag, "_fvalid"}, 32'(f_rValid), 32'd0);
    endtask

    // Random traffic against a queue model; checks every cycle.
    task automatic random_phase(input int cycles, inout logic [DW-1:0] q[$],
                                inout logic ovf_m, inout logic udf_m);
        logic          w, r, wacc, racc;
        logic [DW-1:0] d, exp_d;
        for (int c = 0; c < cycles; c++) begin
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 50);
            d = DW'($urandom_range(0, 511));
            winc = w; rinc = r; wData = d;
            wacc = w && (q.size() < DEPTH);
            racc = r && (q.size() > 0);
            if (w && q.size() == DEPTH) ovf_m = 1'b1;
            if (r && q.size() == 0) udf_m = 1'b1;
            exp_d = '0;
            if (racc) exp_d = q.pop_front();
            if (wacc) q.push_back(d);
            tick();
            check("rnd_count", 32'(s_count), 32'(q.size()));
            check("rnd_svalid", 32'(s_rValid), 32'(racc));
            if (racc) check("rnd_sdata", 32'(s_rData), 32'(exp_d));
            if (q.size() > 0) check("rnd_fdata", 32'(f_rData), 32'(q[0]));
            check("rnd_ovf", 32'(s_ovf), 32'(ovf_m));
            check("rnd_udf", 32'(f_udf), 32'(udf_m));
        end
        idle_inputs();
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic ovf_m, udf_m;

        idle_inputs();
        rst = 1'b0;
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1. reset state and underflow
        check("rst_count", 32'(s_count), 32'd0);
        check("rst_empty", 32'(s_rEmpty), 32'd1);
        check("rst_valid", 32'(s_rValid), 32'd0);
        check("rst_full", 32'(s_wFull), 32'd0);
        check("rst_half", 32'(s_half), 32'd0);
        check("rst_ovf", 32'(s_ovf), 32'd0);
        check("rst_udf", 32'(s_udf), 32'd0);
        check("rst_sdata", 32'(s_rData), 32'd0);
        check("rst_fvalid", 32'(f_rValid), 32'd0);
        check("rst_fdata", 32'(f_rData), 32'd0);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        check("udf_set", 32'(s_udf), 32'd1);
        check("udf_count", 32'(s_count), 32'd0);
        tick();
        check("udf_sticky", 32'(s_udf), 32'd1);
        check("udf_sticky_f", 32'(f_udf), 32'd1);
        do_flush();
        check_cleared("flush1");

        // 2. fill 16 then drain 16
        for (int i = 1; i <= DEPTH; i++) begin
            winc = 1'b1;
            wData = DW'(i);
            tick();
            check("fill_count", 32'(s_count), 32'(i));
            check("fill_half", 32'(s_half), 32'(i >= 8));
            check("fill_af", 32'(s_af), 32'(i >= 12));
        end
        winc = 1'b0;
        check("fill_full", 32'(s_wFull), 32'd1);
        check("fill_ovf", 32'(s_ovf), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_fhead", 32'(f_rData), 32'(i));
            rinc = 1'b1;
            tick();
            check("drain_sdata", 32'(s_rData), 32'(i));
            check("drain_svalid", 32'(s_rValid), 32'd1);
            check("drain_count", 32'(s_count), 32'(DEPTH - i));
            check("drain_ae", 32'(s_ae), 32'((DEPTH - i) <= 3));
        end
        rinc = 1'b0;
        tick();
        check("drain_vdrop", 32'(s_rValid), 32'd0);
        check("drain_hold", 32'(s_rData), 32'h10);
        check("drain_empty", 32'(s_rEmpty), 32'd1);
        check("drain_udf", 32'(s_udf), 32'd0);

        // 3. simultaneous ops when full and when empty
        for (int i = 1; i <= DEPTH; i++) begin
            winc = 1'b1;
            wData = DW'(32'h100 + i);
            tick();
        end
        check("full3", 32'(s_wFull), 32'd1);
        winc = 1'b1; rinc = 1'b1; wData = 9'h1FF;
        tick();
        check("fullrw_count", 32'(s_count), 32'd15);
        check("fullrw_ovf", 32'(s_ovf), 32'd1);
        check("fullrw_sdata", 32'(s_rData), 32'h101);
        check("fullrw_fhead", 32'(f_rData), 32'h102);
        winc = 1'b0;
        for (int i = 2; i <= DEPTH; i++) begin
            tick();
            check("fullrw_drain", 32'(s_rData), 32'(32'h100 + i));
        end
        rinc = 1'b0;
        tick();
        check("fullrw_empty", 32'(s_rEmpty), 32'd1);
        check("fullrw_ovfkeep", 32'(s_ovf), 32'd1);
        winc = 1'b1; rinc = 1'b1; wData = 9'h077;
        tick();
        winc = 1'b0; rinc = 1'b0;
        check("emptyrw_count", 32'(s_count), 32'd1);
        check("emptyrw_udf", 32'(s_udf), 32'd1);
        check("emptyrw_fudf", 32'(f_udf), 32'd1);
        check("emptyrw_svalid", 32'(s_rValid), 32'd0);
        check("emptyrw_fdata", 32'(f_rData), 32'h077);
        do_flush();
        check_cleared("flush3");

        // 4. thresholds change combinationally
        for (int i = 0; i < 5; i++) begin
            winc = 1'b1;
            wData = DW'(i);
            tick();
        end
        winc = 1'b0;
        check("thr_ae_off", 32'(s_ae), 32'd0);
        check("thr_af_off", 32'(s_af), 32'd0);
        ae_thresh = 5'd16;
        #1;
        check("thr_ae_max", 32'(s_ae), 32'd1);
        af_thresh = 5'd0;
        #1;
        check("thr_af_zero", 32'(s_af), 32'd1);
        af_thresh = 5'd5;
        ae_thresh = 5'd4;
        #1;
        check("thr_af_eq", 32'(s_af), 32'd1);
        check("thr_ae_below", 32'(s_ae), 32'd0);
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        do_flush();
        check_cleared("flush4");

        // 5. FWFT behaviour
        winc = 1'b1; wData = 9'h1AA;
        tick();
        winc = 1'b0;
        check("fwft_valid", 32'(f_rValid), 32'd1);
        check("fwft_head", 32'(f_rData), 32'h1AA);
        check("fwft_svalid", 32'(s_rValid), 32'd0);
        winc = 1'b1; wData = 9'h055;
        tick();
        winc = 1'b0;
        check("fwft_head_keep", 32'(f_rData), 32'h1AA);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        check("fwft_next", 32'(f_rData), 32'h055);
        check("fwft_valid2", 32'(f_rValid), 32'd1);
        check("fwft_sdata", 32'(s_rData), 32'h1AA);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        check("fwft_empty_valid", 32'(f_rValid), 32'd0);
        check("fwft_empty_data", 32'(f_rData), 32'd0);
        check("fwft_sdata2", 32'(s_rData), 32'h055);
        do_flush();
        check_cleared("flush5");

        // 6. random traffic, flush mid-run, reset mid-burst
        ovf_m = 1'b0; udf_m = 1'b0;
        random_phase(120, q, ovf_m, udf_m);
        winc = 1'b1; rinc = 1'b1; wData = 9'h0F0;
        flush = 1'b1;
        tick();
        idle_inputs();
        check_cleared("rnd_flush");
        q.delete(); ovf_m = 1'b0; udf_m = 1'b0;
        random_phase(120, q, ovf_m, udf_m);
        winc = 1'b1; rinc = 1'b1; wData = 9'h0AB;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        idle_inputs();
        check_cleared("rnd_rst");
        check("rnd_rst_sdata", 32'(s_rData), 32'd0);
        check("rnd_rst_svalid", 32'(s_rValid), 32'd0);
        q.delete(); ovf_m = 1'b0; udf_m = 1'b0;
        random_phase(120, q, ovf_m, udf_m);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
